step_input_conditioner: RTL

//   Upstream front end for the even/odd step counter. Cleans up the board inputs
//   and turns them into control signals for that counter:
//   - synchronises and debounces the EO slide switch and the STEP push-button;
//   - generates a one-cycle step pulse from either a button press or a 1 Hz prescaler;
//   - generates a one-cycle eo_changed pulse, so the counter reloads its 0/1 start value.
//   The counter advances on the cycle where step_tick is high.

---
 rtl/step_input_conditioner.sv | 101 ++++++++++
 1 files changed

// File: rtl/step_input_conditioner.sv
// Board input front end for the even/odd step counter: synchronises and debounces
// the EO switch, STEP button and auto-step switch, and produces eo, eo_changed and step_tick.
module step_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic eo_raw,
  input  logic step_n_raw,
  input  logic auto_en_raw,
  output logic eo,
  output logic eo_changed,
  output logic step_tick
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

  // Lane 0 = EO switch, lane 1 = STEP button (active-low), lane 2 = auto-step switch.
  logic [2:0] w_raw;
  logic [2:0] w_db;
  logic [2:0] w_done;

  assign w_raw = {auto_en_raw, step_n_raw, eo_raw};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      localparam logic DB_RST = (gi == 1);
      logic          r_s1;
      logic          r_s2;
      logic          r_db;
      logic [DW-1:0] r_cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_s1  <= 1'b0;
          r_s2  <= 1'b0;
          r_db  <= DB_RST;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          if (r_s2 == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_db  <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_db[gi]   = r_db;
      assign w_done[gi] = (r_s2 != r_db) && (r_cnt == DB_LAST);
    end
  endgenerate

  logic          r_btn_prev;
  logic          r_eo_changed;
  logic          r_step_tick;
  logic [PW-1:0] r_pre;
  logic          w_press;
  logic          w_auto;
  logic          w_eo_upd;
  logic          w_step_next;

  assign w_press  = r_btn_prev & ~w_db[1];
  assign w_auto   = w_db[2] && (r_pre == PRE_LAST);
  assign w_eo_upd = w_done[0];
  // An EO reload swallows any step due at the same edge; back-to-back steps are
  // only possible when the prescaler itself fires every cycle.
  assign w_step_next = (w_press | w_auto) & ~w_eo_upd &
                       ((TICK_CYCLES == 1) | ~r_step_tick);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_prev   <= 1'b1;
      r_eo_changed <= 1'b0;
      r_step_tick  <= 1'b0;
      r_pre        <= '0;
    end else begin
      r_btn_prev   <= w_db[1];
      r_eo_changed <= w_eo_upd;
      r_step_tick  <= w_step_next;
      if (!w_db[2] || w_eo_upd || w_auto) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign eo         = w_db[0];
  assign eo_changed = r_eo_changed;
  assign step_tick  = r_step_tick;

endmodule
